// File: rtl/sipo_pkg.sv
// Shared types and limits for the serial-in/parallel-out capture stage.
package sipo_pkg;

    localparam int unsigned SIPO_MAX_WIDTH = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register; flags a write that finds the entry full and not draining.
module sipo_out_buf #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             drop
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             can_write;

    always_comb begin
        // A full entry can still take a word if it is being drained this cycle.
        can_write = ~valid_q | rd_ready;
        data_d    = data_q;
        valid_d   = valid_q;
        if (wr_en && can_write) begin
            data_d  = wr_data;
            valid_d = 1'b1;
        end else if (valid_q && rd_ready) begin
            valid_d = 1'b0;
        end
        drop = wr_en & ~can_write;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/sipo_capture.sv
// Reassembles an MSB-first serial stream into WIDTH-bit words aligned on a frame-start strobe,
// with sticky overrun and resync flags.
module sipo_capture
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             start,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             sync_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > SIPO_MAX_WIDTH) begin : g_bad_width
        $error("sipo_capture: WIDTH out of range 2..32");
    end

    sipo_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             overrun_q, overrun_d;
    logic             sync_err_q, sync_err_d;
    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             resync;
    logic             drop;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        word      = {shreg_q[WIDTH-2:0], sin};
        word_done = 1'b0;
        resync    = 1'b0;
        if (sin_en) begin
            if (start) begin
                // A start always opens a new frame, abandoning any partial one.
                resync    = (state_q == SHIFT);
                shreg_d   = {{(WIDTH - 1){1'b0}}, sin};
                bit_cnt_d = CNT_W'(1);
                state_d   = SHIFT;
            end else if (state_q == SHIFT) begin
                shreg_d = word;
                if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                    word_done = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        end
        // Set events win over a simultaneous clear.
        overrun_d  = drop | (overrun_q & ~clr_err);
        sync_err_d = resync | (sync_err_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            overrun_q  <= overrun_d;
            sync_err_q <= sync_err_d;
        end
    end

    sipo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (word_done),
        .wr_data   (word),
        .rd_ready  (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .drop      (drop)
    );

    assign busy     = (state_q == SHIFT);
    assign overrun  = overrun_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_sipo_capture.sv
// Bench for sipo_capture (WIDTH=4): frame table plus hand-written corner sequences, with a
// scoreboard queue checked at every accepted output word.
module tb_sipo_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sin = 1'b0;
    logic       sin_en = 1'b0;
    logic       start = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] out_data;
    logic       out_valid;
    logic       busy;
    logic       overrun;
    logic       sync_err;

    int tests = 0;
    int fails = 0;
    logic [3:0] sb[$];

    sipo_capture #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_en    (sin_en),
        .start     (start),
        .out_ready (out_ready),
        .clr_err   (clr_err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] bits;
        int         gap;
        logic [3:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every word the consumer accepts must be the oldest expected one.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got %0h, no word expected (t=%0t)", out_data, $time);
            end else begin
                check("sb_word", {28'd0, out_data}, {28'd0, sb.pop_front()});
            end
        end
    end

    // Returns at posedge+1 of the edge that sampled the last bit.
    task automatic send_frame(input logic [3:0] w, input int gap, input logic clr_last,
                              input logic chk_busy);
        for (int i = 3; i >= 0; i--) begin
            sin     = w[i];
            sin_en  = 1'b1;
            start   = (i == 3);
            clr_err = clr_last && (i == 0);
            @(posedge clk); #1;
            sin_en  = 1'b0;
            start   = 1'b0;
            clr_err = 1'b0;
            if (i != 0) begin
                for (int g = 0; g < gap; g++) begin
                    if (chk_busy) begin
                        @(negedge clk);
                        check("busy_gap", {31'd0, busy}, 32'd1);
                    end
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic send_bit(input logic b, input logic st);
        sin    = b;
        sin_en = 1'b1;
        start  = st;
        @(posedge clk); #1;
        sin_en = 1'b0;
        start  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{4'b1011, 0, 4'hB};
        vecs[1] = '{4'b1011, 1, 4'hB};
        vecs[2] = '{4'b1011, 3, 4'hB};
        vecs[3] = '{4'b1010, 0, 4'hA};
        vecs[4] = '{4'b0011, 0, 4'h3};
        vecs[5] = '{4'b1111, 0, 4'hF};
        vecs[6] = '{4'b0110, 2, 4'h6};
        vecs[7] = '{4'b0000, 1, 4'h0};

        // Reset with random inputs
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin
            sin       = 1'($urandom);
            sin_en    = 1'($urandom);
            start     = 1'($urandom);
            out_ready = 1'($urandom);
            clr_err   = 1'($urandom);
            tick();
        end
        rst = 1'b0; sin = 0; sin_en = 0; start = 0; out_ready = 0; clr_err = 0;
        @(negedge clk);
        check("rst_data", {28'd0, out_data}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_sync_err", {31'd0, sync_err}, 32'd0);
        tick();

        // Table: gapped and full-rate back-to-back frames, consumer always ready
        out_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            sb.push_back(vecs[v].exp_data);
            send_frame(vecs[v].bits, vecs[v].gap, 1'b0, 1'b1);
            @(negedge clk);
            check("lat_valid", {31'd0, out_valid}, 32'd1);
            check("lat_data", {28'd0, out_data}, {28'd0, vecs[v].exp_data});
            check("tbl_overrun", {31'd0, overrun}, 32'd0);
            check("tbl_sync_err", {31'd0, sync_err}, 32'd0);
        end
        tick();
        check("tbl_drained", {31'd0, out_valid}, 32'd0);

        // Hold while not ready, then drain
        out_ready = 1'b0;
        send_frame(4'hB, 0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {28'd0, out_data}, 32'hB);
            tick();
        end
        sb.push_back(4'hB);
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("hold_fall", {31'd0, out_valid}, 32'd0);
        tick();

        // Backpressure: second word dropped; clear on the dropping cycle loses to the set
        out_ready = 1'b0;
        send_frame(4'hB, 0, 1'b0, 1'b0);
        send_frame(4'h6, 0, 1'b1, 1'b0);
        @(negedge clk);
        check("bp_data", {28'd0, out_data}, 32'hB);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_overrun", {31'd0, overrun}, 32'd1);
        check("bp_sync_err", {31'd0, sync_err}, 32'd0);
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        @(negedge clk);
        check("bp_clr", {31'd0, overrun}, 32'd0);
        check("bp_data_kept", {28'd0, out_data}, 32'hB);
        tick();
        sb.push_back(4'hB);
        out_ready = 1'b1;
        tick();
        tick();

        // Resync: partial 1,1 then a new start with 0,1,0,1
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        sb.push_back(4'h5);
        send_frame(4'h5, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("rs_sync_err", {31'd0, sync_err}, 32'd1);
        check("rs_data", {28'd0, out_data}, 32'h5);
        check("rs_overrun", {31'd0, overrun}, 32'd0);
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        @(negedge clk);
        check("rs_clr", {31'd0, sync_err}, 32'd0);
        tick();

        // Reset mid-frame: no word until a fresh start
        sb.push_back(4'hA);
        send_frame(4'hA, 0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_valid", {31'd0, out_valid}, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) send_bit(1'b1, 1'b0);
        @(negedge clk);
        check("mr_no_word", {31'd0, out_valid}, 32'd0);
        check("mr_no_busy", {31'd0, busy}, 32'd0);
        sb.push_back(4'hC);
        send_frame(4'hC, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("mr_new_word", {28'd0, out_data}, 32'hC);
        tick();

        // Reset mid-handshake drops the buffered word
        out_ready = 1'b0;
        send_frame(4'h9, 0, 1'b0, 1'b0);
        @(negedge clk);
        check("mh_valid_pre", {31'd0, out_valid}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mh_valid", {31'd0, out_valid}, 32'd0);
        check("mh_data", {28'd0, out_data}, 32'd0);
        tick();

        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
